// File: rtl/lcd_scanout_pkg.sv
// Shared timing defaults for the LCD scanout path and the framebuffer sizing.
package lcd_scanout_pkg;

  localparam int unsigned DEF_H_ACTIVE = 480;
  localparam int unsigned DEF_H_FP     = 8;
  localparam int unsigned DEF_H_SYNC   = 4;
  localparam int unsigned DEF_H_BP     = 43;
  localparam int unsigned DEF_V_ACTIVE = 272;
  localparam int unsigned DEF_V_FP     = 4;
  localparam int unsigned DEF_V_SYNC   = 4;
  localparam int unsigned DEF_V_BP     = 12;
  localparam logic        DEF_HS_POL   = 1'b0;
  localparam logic        DEF_VS_POL   = 1'b0;

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lcd_timing.sv
// Horizontal/vertical position counters and the stage-0 decode of active
// area, sync windows, frame start, last visible pixel and frame wrap.
module lcd_timing
  import lcd_scanout_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic clk,
  input  logic rst_n,
  output logic active_o,
  output logic hs_o,
  output logic vs_o,
  output logic first_o,
  output logic last_px_o,
  output logic wrap_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW = cnt_w(H_TOTAL);
  localparam int unsigned VW = cnt_w(V_TOTAL);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          h_end, v_end;

  // Next position: h wraps every line, v advances on h wrap and wraps per frame.
  always_comb begin
    h_end   = (h_cnt_q == HW'(H_TOTAL - 1));
    v_end   = (v_cnt_q == VW'(V_TOTAL - 1));
    h_cnt_d = h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_end) begin
      h_cnt_d = '0;
      v_cnt_d = v_end ? '0 : v_cnt_q + VW'(1);
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Stage-0 decode of the current position.
  always_comb begin
    active_o  = (h_cnt_q < HW'(H_ACTIVE)) && (v_cnt_q < VW'(V_ACTIVE));
    hs_o      = (h_cnt_q >= HW'(H_ACTIVE + H_FP)) &&
                (h_cnt_q <  HW'(H_ACTIVE + H_FP + H_SYNC));
    vs_o      = (v_cnt_q >= VW'(V_ACTIVE + V_FP)) &&
                (v_cnt_q <  VW'(V_ACTIVE + V_FP + V_SYNC));
    first_o   = (h_cnt_q == '0) && (v_cnt_q == '0);
    last_px_o = (h_cnt_q == HW'(H_ACTIVE - 1)) && (v_cnt_q == VW'(V_ACTIVE - 1));
    wrap_o    = h_end && v_end;
  end

endmodule

// File: rtl/lcd_scanout.sv
// Framebuffer read side: timing generator, incremental read address, and a
// two-stage pipeline aligning RAM data with de/sync at the pads.
module lcd_scanout
  import lcd_scanout_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        HS_POL   = DEF_HS_POL,
  parameter logic        VS_POL   = DEF_VS_POL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] rad,
  input  logic [7:0]  dout,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [7:0]  pixel,
  output logic        frame_start
);

  logic active0, hs0, vs0, first0, last_px0, wrap0;

  lcd_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .active_o  (active0),
    .hs_o      (hs0),
    .vs_o      (vs0),
    .first_o   (first0),
    .last_px_o (last_px0),
    .wrap_o    (wrap0)
  );

  logic [31:0] rad_q, rad_d;
  logic        en_frame_q;
  logic        act1_q, hs1_q, vs1_q, first1_q;
  logic        de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d, fs_q;
  logic [7:0]  pixel_q, pixel_d;

  // Read address tracks the visible pixel index; it stops at the last pixel
  // so it never exceeds H_ACTIVE*V_ACTIVE-1, and restarts at the frame wrap.
  always_comb begin
    rad_d = rad_q;
    if (wrap0) begin
      rad_d = '0;
    end else if (active0 && !last_px0) begin
      rad_d = rad_q + 32'd1;
    end
  end

  // Stage-2 pin values from the stage-1 flags and the RAM data.
  always_comb begin
    de_d    = act1_q && en_frame_q;
    pixel_d = de_d ? dout : 8'd0;
    hsync_d = hs1_q ? HS_POL : ~HS_POL;
    vsync_d = vs1_q ? VS_POL : ~VS_POL;
  end

  // Address, frame enable and both pipeline stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rad_q      <= '0;
      en_frame_q <= 1'b0;
      act1_q     <= 1'b0;
      hs1_q      <= 1'b0;
      vs1_q      <= 1'b0;
      first1_q   <= 1'b0;
      de_q       <= 1'b0;
      pixel_q    <= 8'd0;
      hsync_q    <= ~HS_POL;
      vsync_q    <= ~VS_POL;
      fs_q       <= 1'b0;
    end else begin
      rad_q    <= rad_d;
      // en is only looked at on the frame's first clock to avoid tearing.
      if (first0) en_frame_q <= en;
      act1_q   <= active0;
      hs1_q    <= hs0;
      vs1_q    <= vs0;
      first1_q <= first0;
      de_q     <= de_d;
      pixel_q  <= pixel_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      fs_q     <= first1_q;
    end
  end

  assign rad         = rad_q;
  assign de          = de_q;
  assign pixel       = pixel_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_lcd_scanout.sv
// Bench for lcd_scanout with a small panel geometry (8x6 clocks per frame).
module tb_lcd_scanout;

  localparam int HA = 4, HFP = 1, HS = 2, HBP = 1;
  localparam int VA = 3, VFP = 1, VS = 1, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] rad;
  logic [7:0]  dout = 8'd0;
  logic        hsync, vsync, de, frame_start;
  logic [7:0]  pixel;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;               // clock edges since reset release
  bit en_hist[0:63];       // en seen by the DUT at each frame start

  lcd_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rad(rad), .dout(dout),
    .hsync(hsync), .vsync(vsync), .de(de), .pixel(pixel),
    .frame_start(frame_start)
  );

  // Clock.
  always #5 clk = ~clk;

  // Framebuffer RAM model: one clock read latency, ram[i] = 0x10 + i.
  always @(posedge clk) dout <= 8'h10 + rad[7:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic chk_reset_values();
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_de", 32'(de), 32'd0);
    chk("rst_pixel", 32'(pixel), 32'd0);
    chk("rst_rad", rad, 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
  endtask

  // Reference: outputs after edge n show raster position n-2; rad shows
  // the count of visible pixels passed so far in the frame at position n.
  task automatic check_outputs();
    int pos, h, v, f, cnt;
    bit e_de, e_hs, e_vs, e_fs;
    logic [7:0] e_px;
    h = n % HT;
    v = (n / HT) % VT;
    if (v < VA) cnt = v * HA + ((h < HA) ? h : HA);
    else        cnt = HA * VA;
    if (cnt > HA * VA - 1) cnt = HA * VA - 1;
    chk("rad", rad, 32'(cnt));
    if (n < 2) begin
      e_de = 0; e_px = 8'd0; e_hs = 1; e_vs = 1; e_fs = 0;
    end else begin
      pos  = n - 2;
      h    = pos % HT;
      v    = (pos / HT) % VT;
      f    = pos / FT;
      e_de = (h < HA) && (v < VA) && en_hist[f];
      e_px = e_de ? 8'(8'h10 + v * HA + h) : 8'd0;
      e_hs = !((h >= HA + HFP) && (h < HA + HFP + HS));
      e_vs = !((v >= VA + VFP) && (v < VA + VFP + VS));
      e_fs = (h == 0) && (v == 0);
    end
    chk("de", 32'(de), 32'(e_de));
    chk("pixel", 32'(pixel), 32'(e_px));
    chk("hsync", 32'(hsync), 32'(e_hs));
    chk("vsync", 32'(vsync), 32'(e_vs));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
  endtask

  // One clock: note en at frame starts, advance, check 1 time unit later.
  task automatic step(input int cycles, input int toggle_odds);
    for (int i = 0; i < cycles; i++) begin
      if ((n % FT) == 0) en_hist[n / FT] = en;
      @(posedge clk);
      n++;
      #1;
      check_outputs();
      if (toggle_odds > 0 && $urandom_range(toggle_odds - 1, 0) == 0) en = ~en;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 64; i++) en_hist[i] = 1'b0;
  endtask

  initial begin
    // Reset held for a few clocks.
    en = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_reset_values();
    end
    release_reset();

    // Frame 0: display enabled throughout.
    step(FT, 0);
    // Frame 1: en drops mid-frame, frame still displayed.
    step(20, 0);
    en = 1'b0;
    step(FT - 20, 0);
    // Frame 2: blank; en returns mid-frame.
    step(30, 0);
    en = 1'b1;
    step(FT - 30, 0);
    // Frame 3: displayed again.
    step(FT, 0);
    // Five frames with random en toggling.
    step(5 * FT, 24);
    // Finish the pipeline of the last frame with en steady.
    step($urandom_range(40, 5), 0);

    // Asynchronous reset mid-frame: outputs return within the same cycle.
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_values();
    @(posedge clk);
    #1;
    chk_reset_values();
    en = ($urandom_range(1, 0) == 1);
    release_reset();
    step(FT, 0);
    step(2 * FT, 16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
